background_writer: RTL

//  Write-side counterpart of the 1bpp background bitmap RAM (640x480, address = x + 640*y).

---
 rtl/background_writer_pkg.sv | 16 +
 rtl/background_writer_if.sv | 44 ++++
 rtl/background_writer_addr_gen.sv | 83 ++++++++
 rtl/background_writer.sv | 100 ++++++++++
 4 files changed

// File: rtl/background_writer_pkg.sv
// Screen geometry, address width and shared types for the 1bpp background bitmap writer.
package bg_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 19;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } bgw_state_t;

endpackage

// File: rtl/background_writer_if.sv
// Command, pixel-stream and RAM write-port bundle for background_writer.
// Defining BG_WRITER_FILL_EN adds the fill/fill_color command fields.
interface background_writer_if;
  import bg_pkg::*;

  logic              start;
  coord_t            x0;
  coord_t            y0;
  coord_t            width;
  coord_t            height;
`ifdef BG_WRITER_FILL_EN
  logic              fill;
  logic              fill_color;
`endif
  logic              pix_valid;
  logic              pix_data;
  logic              pix_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data;
  logic              busy;
  logic              done;

`ifdef BG_WRITER_FILL_EN
  modport master (
    output start, x0, y0, width, height, fill, fill_color, pix_valid, pix_data,
    input  pix_ready, mem_we, mem_addr, mem_data, busy, done
  );
  modport slave (
    input  start, x0, y0, width, height, fill, fill_color, pix_valid, pix_data,
    output pix_ready, mem_we, mem_addr, mem_data, busy, done
  );
`else
  modport master (
    output start, x0, y0, width, height, pix_valid, pix_data,
    input  pix_ready, mem_we, mem_addr, mem_data, busy, done
  );
  modport slave (
    input  start, x0, y0, width, height, pix_valid, pix_data,
    output pix_ready, mem_we, mem_addr, mem_data, busy, done
  );
`endif

endinterface

// File: rtl/background_writer_addr_gen.sv
// Rectangle walker: tracks cx/cy and the running row base, and reports the
// RAM address, last-pixel and off-screen status of the current pixel.
module bg_addr_gen
  import bg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  coord_t            x0_i,
  input  coord_t            y0_i,
  input  coord_t            width_i,
  input  coord_t            height_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              clip_o
);

  localparam int AW1 = ADDR_W + 1;

  coord_t x0_q, x0_d, y0_q, y0_d, width_q, width_d, height_q, height_d;
  coord_t cx_q, cx_d, cy_q, cy_d;
  logic [AW1-1:0] rowBase_q, rowBase_d, addrFull;
  logic [10:0]    xSum, ySum;
  logic           rowEnd;

  assign rowEnd   = (cx_q == width_q - 10'd1);
  assign last_o   = rowEnd && (cy_q == height_q - 10'd1);
  assign xSum     = {1'b0, x0_q} + {1'b0, cx_q};
  assign ySum     = {1'b0, y0_q} + {1'b0, cy_q};
  assign addrFull = rowBase_q + AW1'(x0_q) + AW1'(cx_q);
  assign addr_o   = addrFull[ADDR_W-1:0];
  // Rows far below the screen can overflow the row base; those are clipped anyway.
  assign clip_o   = (xSum >= 11'(SCREEN_W)) || (ySum >= 11'(SCREEN_H)) || addrFull[ADDR_W];

  always_comb begin
    x0_d      = x0_q;
    y0_d      = y0_q;
    width_d   = width_q;
    height_d  = height_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    rowBase_d = rowBase_q;
    if (load_i) begin
      x0_d      = x0_i;
      y0_d      = y0_i;
      width_d   = width_i;
      height_d  = height_i;
      cx_d      = '0;
      cy_d      = '0;
      rowBase_d = AW1'(y0_i) * AW1'(SCREEN_W);
    end else if (step_i) begin
      if (rowEnd) begin
        cx_d      = '0;
        cy_d      = cy_q + 10'd1;
        rowBase_d = rowBase_q + AW1'(SCREEN_W);
      end else begin
        cx_d = cx_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q      <= '0;
      y0_q      <= '0;
      width_q   <= '0;
      height_q  <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      rowBase_q <= '0;
    end else begin
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      width_q   <= width_d;
      height_q  <= height_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      rowBase_q <= rowBase_d;
    end
  end

endmodule

// File: rtl/background_writer.sv
// Blits a raster-order 1bpp pixel stream into the background RAM with screen clipping.
// Defining BG_WRITER_FILL_EN adds a solid-fill mode that needs no stream.
module background_writer
  import bg_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  background_writer_if.slave  bus
);

  bgw_state_t        state_q;
  logic              pixReady_q, memWe_q, memData_q, busy_q, done_q;
  logic [ADDR_W-1:0] memAddr_q, genAddr;
  logic              startAcc, emptyRect, beat, pixBit, genLast, genClip;

  assign startAcc  = (state_q == IDLE) && bus.start;
  assign emptyRect = (bus.width == '0) || (bus.height == '0);

`ifdef BG_WRITER_FILL_EN
  logic fillMode_q, fillColor_q;
  // Fill mode writes one pixel every STREAM cycle and never handshakes.
  assign beat   = (state_q == STREAM) && (fillMode_q || (pixReady_q && bus.pix_valid));
  assign pixBit = fillMode_q ? fillColor_q : bus.pix_data;
`else
  assign beat   = (state_q == STREAM) && pixReady_q && bus.pix_valid;
  assign pixBit = bus.pix_data;
`endif

  bg_addr_gen u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (startAcc),
    .step_i   (beat),
    .x0_i     (bus.x0),
    .y0_i     (bus.y0),
    .width_i  (bus.width),
    .height_i (bus.height),
    .addr_o   (genAddr),
    .last_o   (genLast),
    .clip_o   (genClip)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pixReady_q  <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memData_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef BG_WRITER_FILL_EN
      fillMode_q  <= 1'b0;
      fillColor_q <= 1'b0;
`endif
    end else begin
      memWe_q <= beat && !genClip;
      if (beat) begin
        memAddr_q <= genAddr;
        memData_q <= pixBit;
      end
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q  <= 1'b1;
            state_q <= emptyRect ? DONE : STREAM;
`ifdef BG_WRITER_FILL_EN
            fillMode_q  <= bus.fill;
            fillColor_q <= bus.fill_color;
            pixReady_q  <= !emptyRect && !bus.fill;
`else
            pixReady_q  <= !emptyRect;
`endif
          end
        end
        STREAM: begin
          if (beat && genLast) begin
            state_q    <= DONE;
            pixReady_q <= 1'b0;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pix_ready = pixReady_q;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_data  = memData_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
